pc_fetch: RTL and testbench

//  Instruction-fetch stage sitting directly upstream of the ALU datapath. It owns the PC, fetches
//  one instruction at a time from instruction memory over a req/gnt/rvalid handshake, and

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_fetch.sv | 110 +++++++++++
 tb/tb_pc_fetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: reset vector, canonical NOP and
// the fetch-stage state encoding.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        VALID
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at
// a time and selects PC+4 or the branch target for the next fetch.
module pc_fetch
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC =
        ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Branch,
    input  logic                  Zero,
    input  logic [ADDR_WIDTH-1:0] ImmOp,
    input  logic                  Stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic                  InstrValid,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  PCsrc,
    output logic                  FetchErr
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  misaligned;

    assign imem_addr = fetch_pc;

    // Target is forced to a word boundary; the fault is only flagged.
    always_comb begin
        PCsrc = (state == VALID) & ~Stall & Branch & Zero;
        target = PC + ImmOp;
        misaligned = PCsrc & (target[1:0] != 2'b00);
        if (PCsrc)
            next_pc = {target[ADDR_WIDTH-1:2], 2'b00};
        else
            next_pc = PC + ADDR_WIDTH'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            PC         <= RESET_PC;
            Instr      <= NOP;
            InstrValid <= 1'b0;
            imem_req   <= 1'b0;
            FetchErr   <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        cnt      <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (imem_rvalid) begin
                        Instr      <= imem_rdata;
                        PC         <= fetch_pc;
                        InstrValid <= 1'b1;
                        state      <= VALID;
                    end else if (cnt == LAST) begin
                        Instr      <= NOP;
                        PC         <= fetch_pc;
                        InstrValid <= 1'b1;
                        FetchErr   <= 1'b1;
                        state      <= VALID;
                    end
                end
                VALID: begin
                    if (!Stall) begin
                        InstrValid <= 1'b0;
                        fetch_pc   <= next_pc;
                        imem_req   <= 1'b1;
                        state      <= REQ;
                        if (misaligned)
                            FetchErr <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch with a queue of expected
// (PC, Instr) pairs filled as the memory model grants requests.
module tb_pc_fetch;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] ImmOp = '0;
    logic        Stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic        PCsrc;
    logic        FetchErr;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    pc_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC(RST_PC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Branch(Branch),
        .Zero(Zero),
        .ImmOp(ImmOp),
        .Stall(Stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .Instr(Instr),
        .InstrValid(InstrValid),
        .PC(PC),
        .PCsrc(PCsrc),
        .FetchErr(FetchErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t sb_pop();
        exp_t e;
        e.addr = 32'hxxxx_xxxx;
        e.instr = 32'hxxxx_xxxx;
        if (sb.size() != 0)
            e = sb.pop_front();
        return e;
    endfunction

    // Memory model: waits for a request, grants it, answers after lat cycles.
    task automatic serve(input logic [31:0] data, input int lat,
                         output logic [31:0] addr, output bit ok);
        ok = 1'b0;
        addr = 32'hxxxx_xxxx;
        for (int i = 0; i < 20 && !imem_req; i++)
            tick();
        if (!imem_req)
            return;
        addr = imem_addr;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        sb.push_back('{addr, data});
        repeat (lat - 1) tick();
        imem_rvalid = 1'b1;
        imem_rdata = data;
        tick();
        imem_rvalid = 1'b0;
        ok = InstrValid;
    endtask

    task automatic fetch_check(input string name, input logic [31:0] data,
                               input int lat, input logic [31:0] exp_addr);
        logic [31:0] a;
        bit ok;
        exp_t e;
        serve(data, lat, a, ok);
        tests++;
        if (!ok || a !== exp_addr) begin
            fails++;
            $display("FAIL %s addr: got %h ok=%0d, want %h",
                     name, a, ok, exp_addr);
        end
        e = sb_pop();
        tests++;
        if ({InstrValid, Instr, PC} !== {1'b1, e.instr, e.addr}) begin
            fails++;
            $display("FAIL %s data: got v=%b i=%h pc=%h, want i=%h pc=%h",
                     name, InstrValid, Instr, PC, e.instr, e.addr);
        end
    endtask

    task automatic take_branch(input logic z, input logic [31:0] imm,
                               input logic exp_src, input string name);
        Branch = 1'b1;
        Zero = z;
        ImmOp = imm;
        #1;
        tests++;
        if (PCsrc !== exp_src) begin
            fails++;
            $display("FAIL %s PCsrc: got %b want %b", name, PCsrc, exp_src);
        end
        tick();
        Branch = 1'b0;
        Zero = 1'b0;
        ImmOp = '0;
        #1;
        tests++;
        if (PCsrc !== 1'b0 || InstrValid !== 1'b0) begin
            fails++;
            $display("FAIL %s strobe: got PCsrc=%b v=%b want 0 0",
                     name, PCsrc, InstrValid);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if ({PC, Instr, InstrValid, imem_req, FetchErr, PCsrc} !==
            {RST_PC, NOP, 4'b0000}) begin
            fails++;
            $display("FAIL reset: pc=%h i=%h v=%b req=%b err=%b src=%b",
                     PC, Instr, InstrValid, imem_req, FetchErr, PCsrc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        exp_t e;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL first_req: req=%b addr=%h want 1 %h",
                     imem_req, imem_addr, RST_PC);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        sb.push_back('{RST_PC, 32'h0050_0093});
        tests++;
        if (imem_req !== 1'b0 || InstrValid !== 1'b0) begin
            fails++;
            $display("FAIL first_wait: req=%b v=%b want 0 0",
                     imem_req, InstrValid);
        end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        e = sb_pop();
        tests++;
        if ({InstrValid, Instr, PC} !== {1'b1, e.instr, e.addr}) begin
            fails++;
            $display("FAIL first_data cycle3: v=%b i=%h pc=%h want %h %h",
                     InstrValid, Instr, PC, e.instr, e.addr);
        end
    endtask

    task automatic test_sequential();
        tick();
        tests++;
        if (InstrValid !== 1'b0 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL seq_pulse: v=%b req=%b want 0 1",
                     InstrValid, imem_req);
        end
        fetch_check("seq4", 32'h0010_0113, 1, RST_PC + 32'd4);
        tick();
        fetch_check("seq8", 32'h0020_0193, 3, RST_PC + 32'd8);
    endtask

    task automatic test_branch();
        take_branch(1'b1, 32'hFFFF_FFF8, 1'b1, "br_taken");
        fetch_check("br_tgt", 32'h1111_1111, 2, RST_PC);
        tick();
        fetch_check("br_s4", 32'h2222_2222, 1, RST_PC + 32'd4);
        tick();
        fetch_check("br_s8", 32'h3333_3333, 1, RST_PC + 32'd8);
        take_branch(1'b0, 32'hFFFF_FFF8, 1'b0, "br_not");
        fetch_check("br_fall", 32'h4444_4444, 1, RST_PC + 32'd12);
    endtask

    task automatic test_stall();
        logic [31:0] si, sp;
        si = Instr;
        sp = PC;
        Stall = 1'b1;
        Branch = 1'b1;
        Zero = 1'b1;
        ImmOp = 32'h100;
        imem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({Instr, PC, InstrValid, imem_req, PCsrc} !==
                {si, sp, 3'b100}) begin
                fails++;
                $display("FAIL stall%0d: i=%h pc=%h v=%b req=%b src=%b",
                         i, Instr, PC, InstrValid, imem_req, PCsrc);
            end
        end
        imem_gnt = 1'b0;
        Stall = 1'b0;
        Branch = 1'b0;
        Zero = 1'b0;
        ImmOp = '0;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== sp + 32'd4) begin
            fails++;
            $display("FAIL stall_rel: req=%b addr=%h want 1 %h",
                     imem_req, imem_addr, sp + 32'd4);
        end
        fetch_check("stall_fetch", 32'h5555_5555, 1, sp + 32'd4);
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        tick();
        a = imem_addr;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        repeat (TIMEOUT - 1) tick();
        tests++;
        if (InstrValid !== 1'b0 || FetchErr !== 1'b0) begin
            fails++;
            $display("FAIL to_early: v=%b err=%b want 0 0",
                     InstrValid, FetchErr);
        end
        tick();
        tests++;
        if ({Instr, PC, InstrValid, FetchErr} !== {NOP, a, 2'b11}) begin
            fails++;
            $display("FAIL to_fire: i=%h pc=%h v=%b err=%b want %h %h 1 1",
                     Instr, PC, InstrValid, FetchErr, NOP, a);
        end
        tick();
        fetch_check("to_next", 32'h6666_6666, 1, a + 32'd4);
        tests++;
        if (FetchErr !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky: err=%b want 1", FetchErr);
        end
    endtask

    task automatic test_reset_midfetch();
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({PC, Instr, InstrValid, imem_req, FetchErr} !==
            {RST_PC, NOP, 3'b000}) begin
            fails++;
            $display("FAIL midrst: pc=%h i=%h v=%b req=%b err=%b",
                     PC, Instr, InstrValid, imem_req, FetchErr);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        fetch_check("rst_refetch", 32'h0050_0093, 1, RST_PC);
    endtask

    task automatic test_misaligned();
        tests++;
        if (FetchErr !== 1'b0) begin
            fails++;
            $display("FAIL mis_pre: err=%b want 0", FetchErr);
        end
        take_branch(1'b1, 32'd6, 1'b1, "mis6");
        tests++;
        if (FetchErr !== 1'b1) begin
            fails++;
            $display("FAIL mis_err: err=%b want 1", FetchErr);
        end
        fetch_check("mis6_tgt", 32'h7777_7777, 1, RST_PC + 32'd4);
        take_branch(1'b1, 32'hFFFF_FFFE, 1'b1, "mis_neg");
        fetch_check("misneg_tgt", 32'h8888_8888, 1, RST_PC);
    endtask

    task automatic test_wrap();
        take_branch(1'b1, 32'h403F_FFFC, 1'b1, "wrap_br");
        fetch_check("wrap_top", 32'h9999_9999, 1, 32'hFFFF_FFFC);
        tick();
        fetch_check("wrap_zero", 32'hAAAA_AAAA, 1, 32'h0000_0000);
    endtask

    task automatic test_handshake();
        exp_t e;
        tick();
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        sb.push_back('{imem_addr, 32'h0BAD_F00D});
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        tests++;
        if (InstrValid !== 1'b0) begin
            fails++;
            $display("FAIL hs_early: v=%b want 0", InstrValid);
        end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD_F00D;
        tick();
        imem_rvalid = 1'b0;
        e = sb_pop();
        tests++;
        if ({InstrValid, Instr, PC} !== {1'b1, e.instr, e.addr}) begin
            fails++;
            $display("FAIL hs_data: v=%b i=%h pc=%h want %h %h",
                     InstrValid, Instr, PC, e.instr, e.addr);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_stall();
        test_timeout();
        test_reset_midfetch();
        test_misaligned();
        test_wrap();
        test_handshake();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
